// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one FP multiplier between NUM_REQ
// requesters: accept one operand pair, drive the multiplier for MUL_LATENCY
// cycles, capture its registered result, return it over valid/ready.
module fp_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [31:0]             resp_data,
    output logic                    busy,
    output logic [31:0]             mul_a,
    output logic [31:0]             mul_b,
    output logic                    mul_enable,
    input  logic [31:0]             mul_out
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int LW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [PW:0]   NREQ     = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(MUL_LATENCY - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_gnt;
    logic [LW-1:0]      r_lat;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [31:0]        r_resp;

    logic               w_any;
    logic [PW-1:0]      w_gnt_idx;
    logic [PW:0]        w_sum;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [NUM_REQ-1:0] w_cur_oh;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic               w_hs;

    // Round-robin pick: scan from the farthest offset down so the requester
    // closest to ptr (modulo wrap) is the one left standing.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= NREQ)
                w_sum = w_sum - NREQ;
            if (req_valid[w_sum]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_sum[PW-1:0];
            end
        end
    end

    // Decode new grant / held grant to one-hot and mux the granted operands.
    always_comb begin
        w_gnt_oh = '0;
        w_cur_oh = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_gnt_oh[i] = 1'b1;
                w_sel_a     = req_a[32*i +: 32];
                w_sel_b     = req_b[32*i +: 32];
            end
            if (r_gnt == PW'(i))
                w_cur_oh[i] = 1'b1;
        end
    end

    // Only the granted requester's resp_ready completes the response.
    assign w_hs = |(resp_ready & w_cur_oh);

    // Sequencer: IDLE -> ISSUE (MUL_LATENCY cycles) -> CAPTURE -> RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_lat   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        r_gnt   <= w_gnt_idx;
                        r_lat   <= LAT_INIT;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_lat == '0)
                        r_state <= S_CAPTURE;
                    else
                        r_lat <= r_lat - 1'b1;
                end
                S_CAPTURE: begin
                    // Last edge had enable=1; sampling later would see the
                    // multiplier's idle pattern instead of the product.
                    r_resp  <= mul_out;
                    r_state <= S_RESP;
                end
                default: begin
                    if (w_hs) begin
                        r_ptr   <= (r_gnt == LAST_REQ) ? '0 : r_gnt + 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // req_ready is gated by reset so outputs drop without waiting for an edge.
    assign req_ready  = (!reset && r_state == S_IDLE && w_any) ? w_gnt_oh : '0;
    assign resp_valid = (r_state == S_RESP) ? w_cur_oh : '0;
    assign resp_data  = r_resp;
    assign busy       = (r_state != S_IDLE);
    assign mul_enable = (r_state == S_ISSUE);
    assign mul_a      = r_op_a;
    assign mul_b      = r_op_b;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: two instances (MUL_LATENCY 1 and 3),
// each with a table-driven registered multiplier model.
module tb_fp_mul_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [3:0]   req_valid = '0, req_ready, resp_valid, resp_ready = '0;
    logic [127:0] req_a = '0, req_b = '0;
    logic [31:0]  resp_data, mul_a, mul_b, mul_out = '0;
    logic         busy, mul_enable;

    logic [3:0]   req_valid3 = '0, req_ready3, resp_valid3, resp_ready3 = '0;
    logic [127:0] req_a3 = '0, req_b3 = '0;
    logic [31:0]  resp_data3, mul_a3, mul_b3, mul_out3 = '0;
    logic         busy3, mul_enable3;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_p [4] = '{32'h40C00000, 32'h40000000, 32'hC0400000, 32'h40800000};

    always #5 clk = ~clk;

    fp_mul_arbiter #(.NUM_REQ(4), .MUL_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
        .mul_enable(mul_enable), .mul_out(mul_out)
    );

    fp_mul_arbiter #(.NUM_REQ(4), .MUL_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
        .req_ready(req_ready3), .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_data(resp_data3), .busy(busy3), .mul_a(mul_a3), .mul_b(mul_b3),
        .mul_enable(mul_enable3), .mul_out(mul_out3)
    );

    // Known products of the directed operand pairs; anything else is a qNaN.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40000000_40400000: return 32'h40C00000;
            64'h40800000_3F000000: return 32'h40000000;
            64'h3FC00000_C0000000: return 32'hC0400000;
            64'h40000000_40000000: return 32'h40800000;
            64'h3F800000_3F800000: return 32'h3F800000;
            default:               return 32'h7FC00000;
        endcase
    endfunction

    // Multiplier model: registered product when enabled, idle pattern otherwise.
    always @(posedge clk) begin
        mul_out  <= mul_enable  ? fmul(mul_a,  mul_b)  : 32'h00000DEF;
        mul_out3 <= mul_enable3 ? fmul(mul_a3, mul_b3) : 32'h00000DEF;
    end

    task automatic set_ops;
        req_a[31:0]   = 32'h40000000; req_b[31:0]   = 32'h40400000;
        req_a[63:32]  = 32'h40800000; req_b[63:32]  = 32'h3F000000;
        req_a[95:64]  = 32'h3FC00000; req_b[95:64]  = 32'hC0000000;
        req_a[127:96] = 32'h40000000; req_b[127:96] = 32'h40000000;
    endtask

    task automatic test_reset;
        #1;
        n_chk++; if ({req_ready, resp_valid, busy, mul_enable} !== 10'b0)
            $display("FAIL reset_ctrl got=%b exp=0", {req_ready, resp_valid, busy, mul_enable}); else n_pass++;
        n_chk++; if ({resp_data, mul_a, mul_b} !== 96'b0)
            $display("FAIL reset_data got=%h exp=0", {resp_data, mul_a, mul_b}); else n_pass++;
        n_chk++; if ({req_ready3, resp_valid3, busy3, mul_enable3} !== 10'b0)
            $display("FAIL reset_ctrl3 got=%b exp=0", {req_ready3, resp_valid3, busy3, mul_enable3}); else n_pass++;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single;
        set_ops();
        resp_ready = 4'b1111;
        req_valid  = 4'b0001;
        #1;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL single_accept got=%b exp=0001", req_ready); else n_pass++;
        @(negedge clk); req_valid = '0;
        n_chk++; if (mul_enable !== 1'b1) $display("FAIL single_issue_en got=%b exp=1", mul_enable); else n_pass++;
        n_chk++; if ({mul_a, mul_b} !== 64'h40000000_40400000)
            $display("FAIL single_issue_ops got=%h exp=4000000040400000", {mul_a, mul_b}); else n_pass++;
        n_chk++; if (req_ready !== 4'b0) $display("FAIL single_busy_ready got=%b exp=0000", req_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if ({mul_enable, resp_valid} !== 5'b0)
            $display("FAIL single_capture got=%b exp=00000", {mul_enable, resp_valid}); else n_pass++;
        @(negedge clk);
        n_chk++; if (resp_valid !== 4'b0001) $display("FAIL single_resp_valid got=%b exp=0001", resp_valid); else n_pass++;
        n_chk++; if (resp_data !== 32'h40C00000) $display("FAIL single_resp_data got=%h exp=40c00000", resp_data); else n_pass++;
        @(negedge clk);
        n_chk++; if ({busy, resp_valid} !== 5'b0) $display("FAIL single_idle got=%b exp=00000", {busy, resp_valid}); else n_pass++;
    endtask

    task automatic test_fairness;
        logic [3:0] oh;
        reset = 1'b1; #1; reset = 1'b0;
        @(negedge clk);
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            n_chk++; if (req_ready !== oh) $display("FAIL fair_grant%0d got=%b exp=%b", k, req_ready, oh); else n_pass++;
            @(negedge clk); @(negedge clk); @(negedge clk);
            n_chk++; if (resp_valid !== oh) $display("FAIL fair_resp_valid%0d got=%b exp=%b", k, resp_valid, oh); else n_pass++;
            n_chk++; if (resp_data !== exp_p[k % 4])
                $display("FAIL fair_resp_data%0d got=%h exp=%h", k, resp_data, exp_p[k % 4]); else n_pass++;
            @(negedge clk);
            #1;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        // ptr is 1 after the fairness run
        req_valid  = 4'b0010;
        resp_ready = 4'b0000;
        #1;
        n_chk++; if (req_ready !== 4'b0010) $display("FAIL bp_accept got=%b exp=0010", req_ready); else n_pass++;
        @(negedge clk); req_valid = 4'b1000;
        @(negedge clk); @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            resp_ready = (c >= 5) ? 4'b0100 : 4'b0000;
            #1;
            n_chk++; if (resp_valid !== 4'b0010) $display("FAIL bp_valid%0d got=%b exp=0010", c, resp_valid); else n_pass++;
            n_chk++; if (resp_data !== 32'h40000000) $display("FAIL bp_data%0d got=%h exp=40000000", c, resp_data); else n_pass++;
            n_chk++; if (mul_enable !== 1'b0) $display("FAIL bp_mul_en%0d got=%b exp=0", c, mul_enable); else n_pass++;
            n_chk++; if (req_ready !== 4'b0) $display("FAIL bp_req_ready%0d got=%b exp=0000", c, req_ready); else n_pass++;
            @(negedge clk);
        end
        resp_ready = 4'b0010;
        #1;
        n_chk++; if (resp_valid !== 4'b0010) $display("FAIL bp_pre_hs got=%b exp=0010", resp_valid); else n_pass++;
        @(negedge clk);
        n_chk++; if ({busy, resp_valid} !== 5'b0) $display("FAIL bp_done got=%b exp=00000", {busy, resp_valid}); else n_pass++;
        n_chk++; if (req_ready !== 4'b1000) $display("FAIL bp_next_grant got=%b exp=1000", req_ready); else n_pass++;
        resp_ready = 4'b1111;
        @(negedge clk); req_valid = '0;
        @(negedge clk); @(negedge clk);
        n_chk++; if (resp_valid !== 4'b1000) $display("FAIL bp_r3_valid got=%b exp=1000", resp_valid); else n_pass++;
        n_chk++; if (resp_data !== 32'h40800000) $display("FAIL bp_r3_data got=%h exp=40800000", resp_data); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic seen;
        // ptr is 0; serve req 2 so ptr moves to 3
        req_valid = 4'b0100;
        #1;
        n_chk++; if (req_ready !== 4'b0100) $display("FAIL rm_r2_accept got=%b exp=0100", req_ready); else n_pass++;
        @(negedge clk); req_valid = '0;
        @(negedge clk); @(negedge clk);
        n_chk++; if (resp_data !== 32'hC0400000) $display("FAIL rm_r2_data got=%h exp=c0400000", resp_data); else n_pass++;
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        n_chk++; if (req_ready !== 4'b0010) $display("FAIL rm_r1_accept got=%b exp=0010", req_ready); else n_pass++;
        @(negedge clk);
        n_chk++; if (mul_enable !== 1'b1) $display("FAIL rm_issue got=%b exp=1", mul_enable); else n_pass++;
        #2; reset = 1'b1; #1;
        n_chk++; if ({req_ready, resp_valid, busy, mul_enable} !== 10'b0)
            $display("FAIL rm_async_ctrl got=%b exp=0", {req_ready, resp_valid, busy, mul_enable}); else n_pass++;
        n_chk++; if ({resp_data, mul_a, mul_b} !== 96'b0)
            $display("FAIL rm_async_data got=%h exp=0", {resp_data, mul_a, mul_b}); else n_pass++;
        req_valid = '0;
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid !== 4'b0) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL rm_no_resp got=%b exp=0", seen); else n_pass++;
        req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h3F800000;
        req_valid = 4'b1001;
        #1;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL rm_ptr_reset got=%b exp=0001", req_ready); else n_pass++;
        @(negedge clk); req_valid = '0;
        @(negedge clk); @(negedge clk);
        n_chk++; if (resp_valid !== 4'b0001) $display("FAIL rm_r0_valid got=%b exp=0001", resp_valid); else n_pass++;
        n_chk++; if (resp_data !== 32'h3F800000) $display("FAIL rm_r0_data got=%h exp=3f800000", resp_data); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_latency3;
        req_a3[31:0] = 32'h40000000; req_b3[31:0] = 32'h40400000;
        resp_ready3 = 4'b1111;
        req_valid3  = 4'b0001;
        #1;
        n_chk++; if (req_ready3 !== 4'b0001) $display("FAIL l3_accept got=%b exp=0001", req_ready3); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (j == 0) req_valid3 = '0;
            n_chk++; if (mul_enable3 !== 1'b1) $display("FAIL l3_en%0d got=%b exp=1", j, mul_enable3); else n_pass++;
        end
        @(negedge clk);
        n_chk++; if ({mul_enable3, resp_valid3} !== 5'b0)
            $display("FAIL l3_capture got=%b exp=00000", {mul_enable3, resp_valid3}); else n_pass++;
        @(negedge clk);
        n_chk++; if (resp_valid3 !== 4'b0001) $display("FAIL l3_resp_valid got=%b exp=0001", resp_valid3); else n_pass++;
        n_chk++; if (resp_data3 !== 32'h40C00000) $display("FAIL l3_resp_data got=%h exp=40c00000", resp_data3); else n_pass++;
        @(negedge clk);
        n_chk++; if (busy3 !== 1'b0) $display("FAIL l3_idle got=%b exp=0", busy3); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_latency3();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
